// File: rtl/tcam_ctrl.sv
// tcam_ctrl: sequencing and arbitration controller for a DEPTH x KEY_W ternary CAM array.
// It accepts row writes (key + don't-care mask) and searches, and round-robins between
// them when both arrive together. It drives the array's row write enables, key bus and
// don't-care bus, and priority-encodes the captured match vector into a registered
// result that is held under a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// wr_ready/srch_ready are combinational, never depend on the matching valid being
// registered, and are only raised while the controller is idle. res_valid stays high
// with a stable result until res_ready is seen.
//
// Optional feature: define TCAM_ROW_VALID_EN to add a per-row valid register. Writes
// set the row's bit, except a write of key all-zeros with mask all-ones, which clears
// it. The captured match vector is gated by these bits, so rows never written (or
// cleared) cannot hit. Without the macro, the raw array match lines are used.
`timescale 1ns/1ps

module tcam_ctrl #(
  parameter int KEY_W      = 8,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4,
  parameter int SEARCH_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [KEY_W-1:0] wr_mask,
  input  logic             srch_valid,
  output logic             srch_ready,
  input  logic [KEY_W-1:0] srch_key,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_multi,
  output logic [DEPTH-1:0] tcam_we,
  output logic [KEY_W-1:0] tcam_key,
  output logic [KEY_W-1:0] tcam_dc,
  input  logic [DEPTH-1:0] tcam_match,
  output logic             busy
);

  localparam int CNT_W = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SEARCH = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t           state;
  logic             last_srch;   // 1 when the most recent accept was a search
  logic [CNT_W-1:0] cnt;         // remaining SEARCH cycles minus one
  logic [DEPTH-1:0] addr_onehot;
  logic [DEPTH-1:0] match_eff;
  logic             enc_hit;
  logic             enc_multi;
  logic [IDX_W-1:0] enc_idx;
  logic             wr_acc;
  logic             srch_acc;

  // Ready generation: only while idle; on a tie the side not granted last time wins.
  always_comb begin
    wr_ready   = 1'b0;
    srch_ready = 1'b0;
    if (state == IDLE) begin
      if (wr_valid && srch_valid) begin
        wr_ready   = last_srch;
        srch_ready = !last_srch;
      end else begin
        wr_ready   = wr_valid;
        srch_ready = srch_valid;
      end
    end
  end

  assign wr_acc   = wr_valid & wr_ready;
  assign srch_acc = srch_valid & srch_ready;

  // Row decode; an address with no matching row (DEPTH not a power of two) yields all zeros.
  always_comb begin
    addr_onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_onehot[i] = (wr_addr == IDX_W'(i));
    end
  end

`ifdef TCAM_ROW_VALID_EN
  logic [DEPTH-1:0] row_valid;

  // Row valid bits follow the write performed in the WRITE cycle (set, or clear on the
  // key=0 / mask=all-ones pattern).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_valid <= '0;
    end else if (state == WRITE) begin
      if ((tcam_dc == '1) && (tcam_key == '0)) begin
        row_valid <= row_valid & ~tcam_we;
      end else begin
        row_valid <= row_valid | tcam_we;
      end
    end
  end

  assign match_eff = tcam_match & row_valid;
`else
  assign match_eff = tcam_match;
`endif

  // Priority encoder: lowest matching row wins; a second match flags multi.
  always_comb begin
    enc_hit   = 1'b0;
    enc_multi = 1'b0;
    enc_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_eff[i]) begin
        if (enc_hit) begin
          enc_multi = 1'b1;
        end else begin
          enc_hit = 1'b1;
          enc_idx = IDX_W'(i);
        end
      end
    end
  end

  // Controller FSM with registered array-side and result-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_srch <= 1'b1;
      cnt       <= '0;
      tcam_we   <= '0;
      tcam_key  <= '0;
      tcam_dc   <= '0;
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_idx   <= '0;
      res_multi <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_acc) begin
            state     <= WRITE;
            last_srch <= 1'b0;
            tcam_we   <= addr_onehot;
            tcam_key  <= wr_key;
            tcam_dc   <= wr_mask;
            busy      <= 1'b1;
          end else if (srch_acc) begin
            state     <= SEARCH;
            last_srch <= 1'b1;
            tcam_key  <= srch_key;
            tcam_dc   <= '0;
            cnt       <= CNT_W'(SEARCH_LAT - 1);
            busy      <= 1'b1;
          end
        end
        WRITE: begin
          state    <= IDLE;
          tcam_we  <= '0;
          tcam_key <= '0;
          tcam_dc  <= '0;
          busy     <= 1'b0;
        end
        SEARCH: begin
          if (cnt == '0) begin
            state     <= RESULT;
            res_valid <= 1'b1;
            res_hit   <= enc_hit;
            res_idx   <= enc_idx;
            res_multi <= enc_multi;
            tcam_key  <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_idx   <= '0;
            res_multi <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcam_ctrl.sv
// tb_tcam_ctrl: self-checking bench for tcam_ctrl. A small ternary array model answers
// the controller's key bus; a transaction-timeline reference model predicts every
// output each cycle; directed sequences pin specific literal results.
`timescale 1ns/1ps

module tb_tcam_ctrl;

  localparam int KW  = 8;
  localparam int D   = 16;
  localparam int IW  = 4;
  localparam int LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [IW-1:0] wr_addr = '0;
  logic [KW-1:0] wr_key = '0;
  logic [KW-1:0] wr_mask = '0;
  logic          srch_valid = 1'b0;
  logic          srch_ready;
  logic [KW-1:0] srch_key = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          res_hit;
  logic [IW-1:0] res_idx;
  logic          res_multi;
  logic [D-1:0]  tcam_we;
  logic [KW-1:0] tcam_key;
  logic [KW-1:0] tcam_dc;
  logic [D-1:0]  tcam_match;
  logic          busy;

  tcam_ctrl #(.KEY_W(KW), .DEPTH(D), .IDX_W(IW), .SEARCH_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_key(wr_key), .wr_mask(wr_mask),
    .srch_valid(srch_valid), .srch_ready(srch_ready), .srch_key(srch_key),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_idx(res_idx), .res_multi(res_multi),
    .tcam_we(tcam_we), .tcam_key(tcam_key), .tcam_dc(tcam_dc),
    .tcam_match(tcam_match), .busy(busy)
  );

  // ---------------- counters / check helper ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic preload = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ternary array model driven by the DUT ----------------
  logic [KW-1:0] arr_key [D];
  logic [KW-1:0] arr_mask[D];
  logic [D-1:0]  arr_match;
  logic          ovr_en = 1'b0;
  logic [D-1:0]  ovr_val = '0;

  always @(posedge clk) begin
    for (int i = 0; i < D; i++) begin
      if (preload) begin
        arr_key[i]  <= KW'(8'h80 + i);
        arr_mask[i] <= '0;
      end else if (tcam_we[i]) begin
        arr_key[i]  <= tcam_key;
        arr_mask[i] <= tcam_dc;
      end
    end
  end

  always_comb begin
    arr_match = '0;
    for (int i = 0; i < D; i++) begin
      arr_match[i] = (((tcam_key ^ arr_key[i]) & ~arr_mask[i] & ~tcam_dc) == '0);
    end
    tcam_match = ovr_en ? ovr_val : arr_match;
  end

  // ---------------- reference model (transaction timeline) ----------------
  logic [KW-1:0] ref_key [D];
  logic [KW-1:0] ref_mask[D];
  logic [D-1:0]  ref_valid;
  int            busy_until, wr_cyc, s_first, s_last, r_from;
  bit            res_pend, m_last_srch;
  logic [D-1:0]  m_we;
  logic [KW-1:0] m_wkey, m_wmask, m_skey;
  bit            e_hit, e_multi;
  logic [IW-1:0] e_idx;

  function automatic logic [D-1:0] ref_vector(input logic [KW-1:0] k);
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) begin
      v[i] = (((k ^ ref_key[i]) & ~ref_mask[i]) == '0);
    end
    return v;
  endfunction

  // Compare process: predicts and checks every output on each falling edge.
  initial begin : compare
    int n;
    bit idle, x_wr, x_sr, x_rv;
    logic [D-1:0] vec;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (preload) begin
          for (int i = 0; i < D; i++) begin
            ref_key[i]  = KW'(8'h80 + i);
            ref_mask[i] = '0;
          end
        end
        ref_valid = '0; busy_until = 0; wr_cyc = -1; s_first = -1; s_last = -2;
        r_from = 0; res_pend = 0; m_last_srch = 1;
      end else begin
        n    = cyc;
        idle = (n >= busy_until) && !res_pend;
        x_wr = idle && wr_valid && (!srch_valid || m_last_srch);
        x_sr = idle && srch_valid && (!wr_valid || !m_last_srch);
        x_rv = res_pend && (n >= r_from);
        chk("wr_ready", wr_ready, x_wr);
        chk("srch_ready", srch_ready, x_sr);
        chk("busy", busy, !idle);
        chk("tcam_we", tcam_we, (n == wr_cyc) ? m_we : '0);
        if (n == wr_cyc) begin
          chk("wr_bus_key", tcam_key, m_wkey);
          chk("wr_bus_dc", tcam_dc, m_wmask);
        end
        if (n >= s_first && n <= s_last) begin
          chk("srch_bus_key", tcam_key, m_skey);
          chk("srch_bus_dc", tcam_dc, '0);
        end
        chk("res_valid", res_valid, x_rv);
        if (x_rv) begin
          chk("res_hit", res_hit, e_hit);
          chk("res_idx", res_idx, e_idx);
          chk("res_multi", res_multi, e_multi);
        end
        // advance the timeline as of the coming rising edge
        if (x_rv && res_ready) begin
          res_pend   = 0;
          busy_until = n + 1;
        end
        if (x_wr) begin
          wr_cyc = n + 1; busy_until = n + 2; m_last_srch = 0;
          m_we = '0; m_we[wr_addr] = 1'b1;
          m_wkey = wr_key; m_wmask = wr_mask;
          ref_key[wr_addr] = wr_key; ref_mask[wr_addr] = wr_mask;
          if (wr_key == '0 && wr_mask == '1) ref_valid[wr_addr] = 1'b0;
          else ref_valid[wr_addr] = 1'b1;
        end
        if (x_sr) begin
          m_last_srch = 1; m_skey = srch_key; res_pend = 1;
          s_first = n + 1; s_last = n + LAT; r_from = n + LAT + 1;
          vec = ovr_en ? ovr_val : ref_vector(srch_key);
`ifdef TCAM_ROW_VALID_EN
          vec = vec & ref_valid;
`endif
          e_hit = (vec != '0); e_multi = ($countones(vec) > 1); e_idx = '0;
          for (int i = D - 1; i >= 0; i--) if (vec[i]) e_idx = IW'(i);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [IW-1:0] a, input logic [KW-1:0] k, input logic [KW-1:0] m);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = a; wr_key = k; wr_mask = m;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk); ok = wr_ready;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    chk("write_accepted", ok, 1);
  endtask

  task automatic do_search(input logic [KW-1:0] k);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    srch_valid = 1'b1; srch_key = k;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk); ok = srch_ready;
      @(posedge clk); #1;
    end
    srch_valid = 1'b0;
    chk("search_accepted", ok, 1);
  endtask

  task automatic wait_result();
    bit ok;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk); ok = res_valid;
    end
    chk("result_seen", ok, 1);
  endtask

  task automatic take_result();
    bit ok;
    ok = 0;
    @(posedge clk); #1; res_ready = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk); ok = res_valid;
    end
    @(posedge clk); #1; res_ready = 1'b0;
    chk("result_taken", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk); ok = !busy && !res_valid;
    end
    chk("drained", ok, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    wr_valid = 0; srch_valid = 0; res_ready = 0;
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_tcam_we", tcam_we, 0);
    chk("rst_tcam_key", tcam_key, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int exp_g[4] = '{0, 1, 0, 1};  // last_grant resets to SEARCH: first tie goes to write

  // ---------------- main sequence ----------------
  initial begin : main
    bit wt, st;
    int g;
    bit got;
    // 1: reset
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    chk("reset_outputs", {res_valid, res_hit, res_idx, res_multi, busy}, 0);
    chk("reset_array_bus", {tcam_we, tcam_key, tcam_dc}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_readies", {wr_ready, srch_ready}, 0);
    chk("idle_busy", busy, 0);

    // 2: write row 3
    do_write(4'd3, 8'hA5, 8'h00);
    @(negedge clk);
    chk("t2_we", tcam_we, 32'h0008);
    chk("t2_key", tcam_key, 32'hA5);
    chk("t2_dc", tcam_dc, 0);
    @(negedge clk);
    chk("t2_we_drop", tcam_we, 0);

    // 3: search hits row 3 after SEARCH_LAT+1 cycles
    do_search(8'hA5);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk); chk("t3_not_yet", res_valid, 0);
    end
    @(negedge clk);
    chk("t3_valid", res_valid, 1);
    chk("t3_result", {res_hit, res_idx, res_multi}, {1'b1, 4'd3, 1'b0});
    take_result();

    // 4: forced match vectors, result held while res_ready low
    do_write(4'd2, 8'h11, 8'h00);
    do_write(4'd4, 8'h22, 8'h00);
    ovr_en = 1'b1; ovr_val = 16'h0014;
    do_search(8'h33);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold", {res_valid, res_hit, res_idx, res_multi}, {1'b1, 1'b1, 4'd2, 1'b1});
    end
    take_result();
    ovr_val = '0;
    do_search(8'h33);
    wait_result();
    chk("t4_miss", {res_hit, res_idx, res_multi}, 0);
    take_result();
    ovr_en = 1'b0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wt = wr_valid && wr_ready;
      st = srch_valid && srch_ready;
      @(posedge clk); #1;
      if (!wr_valid || wt) begin
        wr_valid = ($urandom_range(0, 99) < 35);
        wr_addr  = IW'($urandom_range(0, D - 1));
        wr_key   = KW'($urandom_range(0, 7));
        wr_mask  = ($urandom_range(0, 3) == 0) ? KW'($urandom_range(0, 7)) : '0;
        if ($urandom_range(0, 15) == 0) begin
          wr_key = '0; wr_mask = '1;
        end
      end
      if (!srch_valid || st) begin
        srch_valid = ($urandom_range(0, 99) < 35);
        srch_key   = KW'($urandom_range(0, 7));
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    wr_valid = 0; srch_valid = 0; res_ready = 1;
    wait_idle();
    res_ready = 0;

    // 5: contested grants alternate from reset
    pulse_reset();
    @(posedge clk); #1;
    res_ready = 1; wr_valid = 1; wr_addr = 4'd9; wr_key = 8'h5A; wr_mask = 0;
    srch_valid = 1; srch_key = 8'h5A;
    for (int op = 0; op < 4; op++) begin
      got = 0; g = -1;
      for (int t = 0; t < 64 && !got; t++) begin
        @(negedge clk);
        if (wr_ready) begin got = 1; g = 0; end
        else if (srch_ready) begin got = 1; g = 1; end
        @(posedge clk); #1;
      end
      chk("t5_grant", g, exp_g[op]);
    end
    wr_valid = 0; srch_valid = 0;
    wait_idle();
    res_ready = 0;

    // 6: reset during SEARCH discards the result
    do_search(8'h5A);
    #1 rst = 1'b1;
    #1;
    chk("t6_async", {busy, res_valid, tcam_key, tcam_dc}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk); chk("t6_no_result", res_valid, 0);
    end
    ovr_en = 1'b1; ovr_val = '1;
    do_search(8'h00);
    wait_result();
`ifdef TCAM_ROW_VALID_EN
    chk("t6_unwritten", {res_hit, res_idx, res_multi}, 0);
`else
    chk("t6_all_match", {res_hit, res_idx, res_multi}, {1'b1, 4'd0, 1'b1});
`endif
    take_result();
    ovr_en = 1'b0;

    // reset during WRITE forces the row enable low at once
    do_write(4'd7, 8'h3C, 8'h00);
    #1 rst = 1'b1;
    #1;
    chk("t6_we_async", tcam_we, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
